// File: rtl/mult_pkg.sv
// Shared types and helpers for the byte-sliced multiplier controller.
// Holds funct3 encodings, FSM states, and lane shift-code helpers.
package mult_pkg;

  localparam logic [1:0] F3_MUL    = 2'b00;
  localparam logic [1:0] F3_MULH   = 2'b01;
  localparam logic [1:0] F3_MULHSU = 2'b10;
  localparam logic [1:0] F3_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DRAIN,
    S_DONE
  } state_t;

  // Idle shift codes, lane 3 in the top field: 6,4,2,0.
  localparam logic [11:0] IDLE_SHIFTS = {3'd6, 3'd4, 3'd2, 3'd0};

  // Lane i during phase p holds B byte (i - p) mod 4.
  // The byte's weight is added to the lane's own weight.
  function automatic logic [2:0] shift_code(
    input logic [1:0] lane,
    input logic [1:0] phase
  );
    logic [1:0] j;
    j = lane - phase;
    return {1'b0, lane} + {1'b0, j};
  endfunction

endpackage

// File: rtl/multiplier_ctrl_if.sv
// Request handshake between issuing stage and multiplier controller.
// master drives start/funct3, slave returns busy/done.
interface multiplier_ctrl_if;
  import mult_pkg::*;

  logic       start_i;
  logic [1:0] funct3_i;
  logic       busy_o;
  logic       done_o;

  modport master (
    output start_i,
    output funct3_i,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start_i,
    input  funct3_i,
    output busy_o,
    output done_o
  );

endinterface

// File: rtl/multiplier_ctrl.sv
// Sequencer for the byte-sliced multiplier datapath: accept, 4 phases,
// drain, done. Ports: clk_i, rst_i, req (handshake), datapath controls.
module multiplier_ctrl
  import mult_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  multiplier_ctrl_if.slave req,
  output logic       reg_A_en_o,
  output logic       reg_B_en_o,
  output logic       mux_B_sel_o,
  output logic       rol_en_o,
  output logic       ac_clr_o,
  output logic       AC_en_o,
  output logic       upper_o,
  output logic       signed_A_o,
  output logic [3:0] sig_ctrl_B_o,
  output logic [2:0] shift_0_o,
  output logic [2:0] shift_1_o,
  output logic [2:0] shift_2_o,
  output logic [2:0] shift_3_o
);

  state_t     state;
  logic [1:0] k;
  logic [1:0] k_d;
  logic       b_signed;
  logic       accept;
  logic       is_mult;
  logic       acc_phase;
  logic [11:0] shifts;

  // Reset gates accept so all controls sit at idle values in reset.
  assign accept = req.start_i & ~rst_i
                & ((state == S_IDLE) | (state == S_DONE));

  assign is_mult = (state == S_MULT);

  // Products reach the accumulator one stage after their phase.
  assign acc_phase = (is_mult & (k != 2'd0)) | (state == S_DRAIN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      k        <= 2'd0;
      k_d      <= 2'd0;
      b_signed <= 1'b0;
    end else begin
      k_d <= k;
      if (accept) begin
        state    <= S_MULT;
        k        <= 2'd0;
        b_signed <= (req.funct3_i == F3_MULH);
      end else begin
        unique case (state)
          S_MULT: begin
            k <= k + 2'd1;
            if (k == 2'd3) state <= S_DRAIN;
          end
          S_DRAIN: state <= S_DONE;
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign req.busy_o = (state != S_IDLE);
  assign req.done_o = (state == S_DONE);

  always_comb begin
    reg_A_en_o   = 1'b0;
    reg_B_en_o   = 1'b0;
    mux_B_sel_o  = 1'b0;
    rol_en_o     = 1'b0;
    ac_clr_o     = 1'b0;
    AC_en_o      = 1'b0;
    upper_o      = 1'b0;
    signed_A_o   = 1'b0;
    sig_ctrl_B_o = 4'b0000;
    shifts       = IDLE_SHIFTS;
    unique case (1'b1)
      accept: begin
        reg_A_en_o = 1'b1;
        reg_B_en_o = 1'b1;
        ac_clr_o   = 1'b1;
        upper_o    = (req.funct3_i != F3_MUL);
        signed_A_o = (req.funct3_i == F3_MULH)
                   | (req.funct3_i == F3_MULHSU);
      end
      is_mult: begin
        reg_B_en_o  = (k != 2'd3);
        mux_B_sel_o = (k != 2'd3);
        rol_en_o    = (k != 2'd3);
        for (int i = 0; i < 4; i++) begin
          sig_ctrl_B_o[i] = b_signed
                          & ((2'(i) - k) == 2'd3);
        end
      end
      default: ;
    endcase
    if (acc_phase) begin
      AC_en_o = 1'b1;
      for (int i = 0; i < 4; i++) begin
        shifts[3*i +: 3] = shift_code(2'(i), k_d);
      end
    end
  end

  assign shift_0_o = shifts[2:0];
  assign shift_1_o = shifts[5:3];
  assign shift_2_o = shifts[8:6];
  assign shift_3_o = shifts[11:9];

endmodule
